l2_bus_responder: RTL and testbench

- Synthesizable L2/memory stand-in on the L2 side of bus_ctrl.
- Serves single-word read and write requests with a configurable fixed latency, plus an optional pseudo-random latency.
- Instantiated in bus_ctrl benches and FPGA builds wherever real L2 is absent.
- Keeps running read/write completion counts for scoreboard cross-checking.

---
 rtl/l2_bus_responder.sv | 89 ++++++++
 tb/tb_l2_bus_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/l2_bus_responder.sv
// l2_bus_responder: single-word L2 stand-in with fixed latency and completion counters.
// Define L2_RESP_RAND_LAT_EN to add an LFSR-driven extra latency of 0..RAND_RANGE-1 cycles.
module l2_bus_responder #(
  parameter int WORD_W = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY = 2,
  parameter int RAND_RANGE = 10
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [31:0]         addr,
  input  logic                ren,
  input  logic                wen,
  input  logic [WORD_W-1:0]   wdata,
  input  logic [WORD_W/8-1:0] byte_en,
  output logic [WORD_W-1:0]   rdata,
  output logic                busy,
  output logic                err,
  output logic [31:0]         rd_count,
  output logic [31:0]         wr_count
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int NB = WORD_W / 8;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, nxt;
  logic [WORD_W-1:0] mem [DEPTH_WORDS];
  logic [DEPTH_WORDS-1:0] vld;
  logic [AW-1:0] idx;
  logic [WORD_W-1:0] wd, old, wmerge;
  logic [NB-1:0] be;
  logic is_wr, req;
  logic [31:0] cnt, lat;
  logic unused;
  assign unused = ^{addr[31:AW+2], addr[1:0]};
  assign req = ren | wen;
  assign busy = state != DONE;
`ifdef L2_RESP_RAND_LAT_EN
  logic [15:0] lfsr;
  assign lat = 32'(LATENCY) + 32'(lfsr) % 32'(RAND_RANGE);
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) lfsr <= 16'hACE1;
    else if (state == IDLE && req) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
`else
  assign lat = 32'(LATENCY);
`endif
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = (state == IDLE) ? (req ? WAIT : IDLE) :
          (state == WAIT) ? (!req ? IDLE : (cnt == 0 ? DONE : WAIT)) : IDLE;
  end
  // Words never written since reset read as zero; the valid vector stands in for clearing the array.
  always_comb begin
    old = vld[idx] ? mem[idx] : '0;
    wmerge = old;
    for (int b = 0; b < NB; b++) wmerge[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
  end
  always_ff @(posedge CLK)
    if (state == DONE && is_wr) mem[idx] <= wmerge;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) vld <= '0;
    else if (state == DONE && is_wr) vld[idx] <= 1'b1;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      idx <= '0;
      wd <= '0;
      be <= '0;
      is_wr <= 1'b0;
      cnt <= '0;
      rdata <= '0;
      err <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (state == IDLE && req) begin
        idx <= addr[AW+1:2];
        wd <= wdata;
        be <= byte_en;
        is_wr <= wen;
        cnt <= lat;
        err <= err | (ren & wen);
      end
      if (state == WAIT && req && cnt != 0) cnt <= cnt - 32'd1;
      if (state == WAIT && nxt == DONE && !is_wr) rdata <= old;
      if (state == DONE && is_wr) wr_count <= wr_count + 32'd1;
      if (state == DONE && !is_wr) rd_count <= rd_count + 32'd1;
    end
endmodule

// File: tb/tb_l2_bus_responder.sv
// tb_l2_bus_responder: randomized transactions against a transaction-level memory model,
// checked every cycle, plus directed literal checks.
module tb_l2_bus_responder;
  localparam int LATENCY = 2;
  localparam int RAND_RANGE = 10;
  localparam int DEPTH = 4096;
`ifdef L2_RESP_RAND_LAT_EN
  localparam int EXP_D = 11;
`else
  localparam int EXP_D = 4;
`endif
  logic CLK = 0, nRST = 0, ren = 0, wen = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [3:0] byte_en = 0;
  logic [31:0] rdata, rd_count, wr_count;
  logic busy, err;
  l2_bus_responder #(.WORD_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(LATENCY), .RAND_RANGE(RAND_RANGE)) dut (
    .CLK(CLK), .nRST(nRST), .addr(addr), .ren(ren), .wen(wen), .wdata(wdata), .byte_en(byte_en),
    .rdata(rdata), .busy(busy), .err(err), .rd_count(rd_count), .wr_count(wr_count)
  );
  always #5 CLK = ~CLK;
  int n_cmp = 0, n_bad = 0, cyc = 0, last_low = -1, t_req = 0;
  logic [31:0] m_mem [int];
  logic [31:0] m_rdata = 0, m_rd = 0, m_wr = 0, p_d = 0;
  logic [3:0] p_be = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  bit m_err = 0, m_busy = 1, p_act = 0, p_wr = 0, err_next = 0;
  int p_idx = 0;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at cycle %0d", n, a, e, cyc);
    end
  endfunction

  function automatic logic [31:0] rd_mem(int i);
    return m_mem.exists(i) ? m_mem[i] : 32'h0;
  endfunction

  function automatic int next_lat();
`ifdef L2_RESP_RAND_LAT_EN
    int l;
    l = LATENCY + int'(m_lfsr % 16'(RAND_RANGE));
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    return l;
`else
    return LATENCY;
`endif
  endfunction

  always @(negedge CLK)
    if (nRST) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("rdata", rdata, m_rdata);
      chk("err", 32'(err), 32'(m_err));
      chk("rd_count", rd_count, m_rd);
      chk("wr_count", wr_count, m_wr);
      if (!busy) last_low = cyc;
    end

  // Advance one cycle and apply whatever the previous edge committed.
  task automatic cyc_step();
    logic [31:0] v;
    @(posedge CLK);
    #1;
    cyc++;
    if (err_next) m_err = 1;
    err_next = 0;
    if (p_act) begin
      if (p_wr) begin
        v = rd_mem(p_idx);
        for (int b = 0; b < 4; b++) if (p_be[b]) v[8*b +: 8] = p_d[8*b +: 8];
        m_mem[p_idx] = v;
        m_wr++;
      end else m_rd++;
      p_act = 0;
    end
    m_busy = 1;
  endtask

  task automatic scramble();
    addr = $urandom;
    wdata = $urandom;
    byte_en = 4'($urandom);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      cyc_step();
      ren = 0;
      wen = 0;
      addr = $urandom;
    end
  endtask

  // Returns in the completion cycle (or the drop cycle when aborting).
  task automatic txn(input bit w, input bit both, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input int abort_j);
    int l, aj;
    cyc_step();
    ren = !w || both;
    wen = w || both;
    addr = a;
    wdata = d;
    byte_en = be;
    t_req = cyc;
    l = next_lat();
    if (both) err_next = 1;
    if (abort_j >= 0) begin
      aj = abort_j > l ? l : abort_j;
      for (int k = 0; k < aj; k++) begin
        cyc_step();
        scramble();
      end
      cyc_step();
      ren = 0;
      wen = 0;
      return;
    end
    for (int k = 0; k < 2 + l; k++) begin
      cyc_step();
      scramble();
    end
    m_busy = 0;
    p_act = 1;
    p_wr = w || both;
    p_idx = int'((a >> 2) & 32'(DEPTH - 1));
    p_d = d;
    p_be = be;
    if (!p_wr) m_rdata = rd_mem(p_idx);
  endtask

  task automatic do_reset();
    ren = 0;
    wen = 0;
    nRST = 0;
    m_mem.delete();
    m_rd = 0;
    m_wr = 0;
    m_err = 0;
    m_rdata = 0;
    m_busy = 1;
    p_act = 0;
    err_next = 0;
    m_lfsr = 16'hACE1;
    repeat (2) cyc_step();
    nRST = 1;
  endtask

  initial begin
    bit w, both;
    logic [31:0] a;
    int ab;
    do_reset();
    chk("rst_busy", 32'(busy), 1);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_wr_count", wr_count, 0);
    txn(0, 0, 32'h10, 0, 0, -1);
    chk("rd0_rdata", rdata, 0);
    idle(1);
    chk("rd0_delay", 32'(last_low - t_req), 32'(EXP_D));
    chk("rd0_count", rd_count, 1);
    txn(1, 0, 32'h20, 32'hDEADBEEF, 4'b0011, -1);
    idle(1);
    txn(0, 0, 32'h20, 0, 0, -1);
    chk("be_rdata", rdata, 32'h0000BEEF);
    idle(1);
    chk("be_wr_count", wr_count, 1);
    txn(0, 0, 32'h30, 0, 0, 0);
    idle(3);
    chk("abort_no_done", 32'(last_low < t_req), 1);
    chk("abort_rd_count", rd_count, 2);
    txn(0, 0, 32'h10, 0, 0, -1);
    chk("after_abort_rdata", rdata, 0);
    idle(1);
    chk("after_abort_count", rd_count, 3);
    txn(1, 1, 32'h4, 32'h12345678, 4'hF, -1);
    idle(1);
    chk("both_err", 32'(err), 1);
    chk("both_wr_count", wr_count, 2);
    txn(0, 0, 32'h4, 0, 0, -1);
    chk("both_rdata", rdata, 32'h12345678);
    idle(1);
    chk("both_err_sticky", 32'(err), 1);
    txn(1, 0, 32'h0000_4000, 32'hA5A5A5A5, 4'hF, -1);
    txn(0, 0, 32'h0, 0, 0, -1);
    chk("wrap_rdata", rdata, 32'hA5A5A5A5);
    for (int i = 0; i < 300; i++) begin
      w = 1'($urandom_range(1));
      both = $urandom_range(7) == 0;
      a = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(15)) << 2);
      ab = ($urandom_range(9) == 0) ? int'($urandom_range(12)) : -1;
      txn(w, both, a, $urandom, 4'($urandom), ab);
      idle(int'($urandom_range(2)));
    end
    cyc_step();
    wen = 1;
    ren = 0;
    addr = 32'h40;
    wdata = 32'hCAFEF00D;
    byte_en = 4'hF;
    void'(next_lat());
    cyc_step();
    cyc_step();
    do_reset();
    chk("rst_wait_err", 32'(err), 0);
    chk("rst_wait_wr_count", wr_count, 0);
    txn(0, 0, 32'h40, 0, 0, -1);
    chk("rst_wait_rdata", rdata, 0);
    idle(1);
    txn(1, 0, 32'h44, 32'h0BADF00D, 4'hF, -1);
    do_reset();
    txn(0, 0, 32'h44, 0, 0, -1);
    chk("rst_done_rdata", rdata, 0);
    idle(1);
    chk("rst_done_rd_count", rd_count, 1);
    chk("rst_done_wr_count", wr_count, 0);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
